// File: rtl/procyon_lsu_sq_ctrl.sv
// Store queue control for the LSU.
// Owns the circular head/tail allocation order and steers allocation into the tail entry.
// Launches the oldest retirable store with at most one store in flight.
// Routes update responses back to the launched entry.
// On flush, rewinds the tail so only the nonspeculative entries remain.
module procyon_lsu_sq_ctrl #(
   parameter int OPTN_SQ_DEPTH = 8,
   localparam int SQ_IDX_WIDTH = $clog2(OPTN_SQ_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,

   input  logic                     i_flush,

   input  logic                     i_alloc_req,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [OPTN_SQ_DEPTH-1:0] o_alloc_en,

   input  logic [OPTN_SQ_DEPTH-1:0] i_entry_retirable,
   input  logic [OPTN_SQ_DEPTH-1:0] i_entry_nonspeculative,

   input  logic                     i_retire_ready,
   output logic [OPTN_SQ_DEPTH-1:0] o_retire_en,
   output logic [SQ_IDX_WIDTH-1:0]  o_retire_idx,

   input  logic                     i_update_en,
   input  logic                     i_update_retry,
   input  logic                     i_update_replay,
   input  logic                     i_update_mhq_retry,
   input  logic                     i_update_mhq_replay,
   output logic [OPTN_SQ_DEPTH-1:0] o_update_en,

   output logic [SQ_IDX_WIDTH-1:0]  o_head_idx,
   output logic [SQ_IDX_WIDTH-1:0]  o_tail_idx
);

   typedef enum logic {
      IDLE     = 1'b0,
      LAUNCHED = 1'b1
   } state_t;

   localparam logic [SQ_IDX_WIDTH:0]   DEPTH_CNT = (SQ_IDX_WIDTH+1)'(OPTN_SQ_DEPTH);
   localparam logic [SQ_IDX_WIDTH:0]   CNT_ONE   = (SQ_IDX_WIDTH+1)'(1);
   localparam logic [SQ_IDX_WIDTH-1:0] IDX_ONE   = SQ_IDX_WIDTH'(1);
   localparam logic [OPTN_SQ_DEPTH-1:0] NS_ONE   = OPTN_SQ_DEPTH'(1);

   state_t                    state_r;
   logic [SQ_IDX_WIDTH-1:0]   head_r;
   logic [SQ_IDX_WIDTH-1:0]   tail_r;
   logic [SQ_IDX_WIDTH:0]     count_r;

   logic [OPTN_SQ_DEPTH-1:0]  head_onehot;
   logic [OPTN_SQ_DEPTH-1:0]  tail_onehot;
   logic [SQ_IDX_WIDTH:0]     nspec;
   logic [OPTN_SQ_DEPTH-1:0]  ns_rot;
   logic                      ns_contig;

   logic                      alloc;
   logic                      launch;
   logic                      update;
   logic                      done;
   logic                      complete;

   assign o_full       = (count_r == DEPTH_CNT);
   assign o_empty      = (count_r == '0);
   assign o_head_idx   = head_r;
   assign o_tail_idx   = tail_r;
   assign o_retire_idx = head_r;

   // Decode head and tail pointers into one-hot entry selects
   always_comb begin
      head_onehot         = '0;
      tail_onehot         = '0;
      head_onehot[head_r] = 1'b1;
      tail_onehot[tail_r] = 1'b1;
   end

   // Event qualification; flush suppresses every event in its cycle
   always_comb begin
      alloc    = i_alloc_req & ~o_full & ~i_flush;
      launch   = (state_r == IDLE) & ~o_empty & i_entry_retirable[head_r] &
                 i_retire_ready & ~i_flush;
      update   = (state_r == LAUNCHED) & i_update_en & ~i_flush;
      done     = ~(i_update_retry &
                   (i_update_mhq_retry | i_update_mhq_replay | i_update_replay));
      complete = update & done;
   end

   // Entry strobes driven in the same cycle as the qualifying request
   always_comb begin
      o_alloc_en  = alloc  ? tail_onehot : '0;
      o_retire_en = launch ? head_onehot : '0;
      o_update_en = update ? head_onehot : '0;
   end

   // Count nonspeculative entries; these survive a flush
   always_comb begin
      nspec = '0;
      for (int unsigned i = 0; i < OPTN_SQ_DEPTH; i++) begin
         nspec = nspec + (SQ_IDX_WIDTH+1)'(i_entry_nonspeculative[i]);
      end
   end

   // Rotate nonspeculative bits so head lands at bit 0; a legal pattern is then 2^k-1
   always_comb begin
      ns_rot = '0;
      for (int unsigned i = 0; i < OPTN_SQ_DEPTH; i++) begin
         ns_rot[i] = i_entry_nonspeculative[head_r + SQ_IDX_WIDTH'(i)];
      end
      ns_contig = ((ns_rot & (ns_rot + NS_ONE)) == '0);
   end

   // Pointer, occupancy and launch-state update; flush takes priority over everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
         state_r <= IDLE;
      end else if (i_flush) begin
         // Only the nonspeculative run starting at head survives; tail snaps to its end.
         count_r <= nspec;
         tail_r  <= head_r + nspec[SQ_IDX_WIDTH-1:0];
         state_r <= IDLE;
      end else begin
         if (alloc) begin
            tail_r <= tail_r + IDX_ONE;
         end

         if (complete) begin
            head_r <= head_r + IDX_ONE;
         end

         case ({alloc, complete})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase

         case (state_r)
            IDLE:     if (launch) state_r <= LAUNCHED;
            LAUNCHED: if (update) state_r <= IDLE;
            default:  state_r <= IDLE;
         endcase
      end
   end

   // Nonspeculative entries must form one contiguous run starting at head
   ns_contig_a: assert property (@(posedge clk) disable iff (rst) ns_contig);

endmodule

// File: tb/tb_procyon_lsu_sq_ctrl.sv
// Scoreboard bench for procyon_lsu_sq_ctrl.
// The driver computes the expected outputs from an occupancy/head model and queues them.
// The monitor pops the queued outputs on the falling edge and compares them.
module tb_procyon_lsu_sq_ctrl;

   localparam int D  = 8;
   localparam int IW = 3;

   logic          clk;
   logic          rst;
   logic          i_flush;
   logic          i_alloc_req;
   logic          o_full;
   logic          o_empty;
   logic [D-1:0]  o_alloc_en;
   logic [D-1:0]  i_entry_retirable;
   logic [D-1:0]  i_entry_nonspeculative;
   logic          i_retire_ready;
   logic [D-1:0]  o_retire_en;
   logic [IW-1:0] o_retire_idx;
   logic          i_update_en;
   logic          i_update_retry;
   logic          i_update_replay;
   logic          i_update_mhq_retry;
   logic          i_update_mhq_replay;
   logic [D-1:0]  o_update_en;
   logic [IW-1:0] o_head_idx;
   logic [IW-1:0] o_tail_idx;

   procyon_lsu_sq_ctrl #(.OPTN_SQ_DEPTH(D)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .i_flush                (i_flush),
      .i_alloc_req            (i_alloc_req),
      .o_full                 (o_full),
      .o_empty                (o_empty),
      .o_alloc_en             (o_alloc_en),
      .i_entry_retirable      (i_entry_retirable),
      .i_entry_nonspeculative (i_entry_nonspeculative),
      .i_retire_ready         (i_retire_ready),
      .o_retire_en            (o_retire_en),
      .o_retire_idx           (o_retire_idx),
      .i_update_en            (i_update_en),
      .i_update_retry         (i_update_retry),
      .i_update_replay        (i_update_replay),
      .i_update_mhq_retry     (i_update_mhq_retry),
      .i_update_mhq_replay    (i_update_mhq_replay),
      .o_update_en            (o_update_en),
      .o_head_idx             (o_head_idx),
      .o_tail_idx             (o_tail_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          full;
      logic          empty;
      logic [D-1:0]  alloc_en;
      logic [D-1:0]  retire_en;
      logic [D-1:0]  update_en;
      logic [IW-1:0] retire_idx;
      logic [IW-1:0] head;
      logic [IW-1:0] tail;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: oldest entry, occupancy, and whether a store is in flight
   int   m_head     = 0;
   int   m_count    = 0;
   bit   m_launched = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit alloc, input bit flush, input logic [D-1:0] ret,
                       input int nsk_in, input bit ready, input bit upd,
                       input bit r, input bit rp, input bit mr, input bit mrp);
      exp_t         e;
      int           nsk;
      int           tail;
      logic [D-1:0] ns;
      bit           ok_alloc;
      bit           ok_launch;
      @(posedge clk);
      #1;
      nsk = (nsk_in > m_count) ? m_count : nsk_in;
      ns  = '0;
      for (int k = 0; k < nsk; k++) ns[(m_head + k) % D] = 1'b1;

      i_alloc_req            = alloc;
      i_flush                = flush;
      i_entry_retirable      = ret;
      i_entry_nonspeculative = ns;
      i_retire_ready         = ready;
      i_update_en            = upd;
      i_update_retry         = r;
      i_update_replay        = rp;
      i_update_mhq_retry     = mr;
      i_update_mhq_replay    = mrp;

      tail       = (m_head + m_count) % D;
      ok_alloc   = alloc && (m_count != D) && !flush;
      ok_launch  = !m_launched && (m_count != 0) && ret[m_head] && ready && !flush;
      e.full       = (m_count == D);
      e.empty      = (m_count == 0);
      e.alloc_en   = ok_alloc  ? (D'(1) << tail)   : '0;
      e.retire_en  = ok_launch ? (D'(1) << m_head) : '0;
      e.update_en  = (m_launched && upd && !flush) ? (D'(1) << m_head) : '0;
      e.retire_idx = IW'(m_head);
      e.head       = IW'(m_head);
      e.tail       = IW'(tail);
      sb_q.push_back(e);

      if (flush) begin
         m_count    = nsk;
         m_launched = 1'b0;
      end else begin
         if (m_launched && upd) begin
            if (!(r && (mr || mrp || rp))) begin
               m_head  = (m_head + 1) % D;
               m_count = m_count - 1;
            end
            m_launched = 1'b0;
         end else if (ok_launch) begin
            m_launched = 1'b1;
         end
         if (ok_alloc) m_count = m_count + 1;
      end
   endtask

   // Monitor: compare each queued expectation against the outputs mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("full",       32'(o_full),       32'(e.full));
            chk("empty",      32'(o_empty),      32'(e.empty));
            chk("alloc_en",   32'(o_alloc_en),   32'(e.alloc_en));
            chk("retire_en",  32'(o_retire_en),  32'(e.retire_en));
            chk("update_en",  32'(o_update_en),  32'(e.update_en));
            chk("retire_idx", 32'(o_retire_idx), 32'(e.retire_idx));
            chk("head_idx",   32'(o_head_idx),   32'(e.head));
            chk("tail_idx",   32'(o_tail_idx),   32'(e.tail));
         end
      end
   end

   initial begin
      exp_t rst_e;
      int   alloc_pct;
      rst                    = 1'b1;
      i_flush                = 1'b0;
      i_alloc_req            = 1'b0;
      i_entry_retirable      = '0;
      i_entry_nonspeculative = '0;
      i_retire_ready         = 1'b0;
      i_update_en            = 1'b0;
      i_update_retry         = 1'b0;
      i_update_replay        = 1'b0;
      i_update_mhq_retry     = 1'b0;
      i_update_mhq_replay    = 1'b0;

      #11;
      rst_e.full       = 1'b0;
      rst_e.empty      = 1'b1;
      rst_e.alloc_en   = '0;
      rst_e.retire_en  = '0;
      rst_e.update_en  = '0;
      rst_e.retire_idx = '0;
      rst_e.head       = '0;
      rst_e.tail       = '0;
      sb_q.push_back(rst_e);
      #11;
      rst = 1'b0;

      // Fill: strobes walk 0x01..0x80, then the ninth request is dropped while full
      for (int i = 0; i < 9; i++) step(1, 0, '0, 0, 0, 0, 0, 0, 0, 0);
      // Launch head 0, then complete it
      step(0, 0, '1, 0, 1, 0, 0, 0, 0, 0);
      step(0, 0, '1, 0, 0, 1, 0, 0, 0, 0);
      // Launch head 1, retry response keeps head, then relaunch
      step(0, 0, '1, 0, 1, 0, 0, 0, 0, 0);
      step(0, 0, '1, 0, 0, 1, 1, 0, 1, 0);
      step(0, 0, '1, 0, 1, 0, 0, 0, 0, 0);
      // Completing update together with allocate at count 7, then allocate to full
      step(1, 0, '1, 0, 0, 1, 0, 0, 0, 0);
      step(1, 0, '0, 0, 0, 0, 0, 0, 0, 0);
      // Flush while launched with update and allocate in the same cycle, then relaunch
      step(0, 0, '1, 0, 1, 0, 0, 0, 0, 0);
      step(1, 1, '1, 3, 1, 1, 0, 0, 0, 0);
      step(0, 0, '1, 0, 1, 0, 0, 0, 0, 0);
      step(0, 0, '1, 0, 0, 1, 0, 1, 0, 0);

      // Randomized traffic with alternating fill-heavy and drain-heavy phases
      for (int i = 0; i < 3000; i++) begin
         alloc_pct = ((i / 300) % 2 == 0) ? 80 : 25;
         step($urandom_range(0, 99) < alloc_pct,
              $urandom_range(0, 31) == 0,
              D'($urandom),
              int'($urandom_range(0, D)),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0);
      end

      @(posedge clk);
      #1;
      i_alloc_req = 1'b0;
      i_flush     = 1'b0;
      i_update_en = 1'b0;
      for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(posedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
